// File: rtl/ppu_pkg.sv
// Shared PPUMASK bit positions, palette constants and pixel type for the PPU pixel output stage.
package ppu_pkg;

  localparam int GRAY     = 0;
  localparam int BG_LEFT  = 1;
  localparam int SPR_LEFT = 2;
  localparam int SHOW_BG  = 3;
  localparam int SHOW_SPR = 4;
  localparam int EMPH_LSB = 5;

  localparam logic [4:0] BACKDROP_ADDR = 5'h00;
  localparam logic [5:0] GRAY_MASK     = 6'h30;

  typedef struct packed {
    logic [1:0] pixel;
    logic [1:0] palette;
  } ppu_pix_t;

endpackage

// File: rtl/ppu_pixel_mux_if.sv
// Pixel-in / palette RAM / colour-out signal bundle of the PPU pixel mux.
interface ppu_pixel_mux_if;

  logic       pixel_en;
  logic [7:0] pixel_x;
  logic [1:0] bg_pixel;
  logic [1:0] bg_palette;
  logic [1:0] spr_pixel;
  logic [1:0] spr_palette;
  logic       spr_behind;
  logic       spr_is_zero;
  logic [7:0] ppumask_in;
  logic       sprite0_clear;
  logic [4:0] pal_addr;
  logic       pal_rd_en;
  logic [5:0] pal_data;
  logic [5:0] color_out;
  logic [2:0] emphasis_out;
  logic       color_valid;
  logic       sprite0_hit;

  modport master (
    output pixel_en, pixel_x, bg_pixel, bg_palette, spr_pixel, spr_palette,
           spr_behind, spr_is_zero, ppumask_in, sprite0_clear, pal_data,
    input  pal_addr, pal_rd_en, color_out, emphasis_out, color_valid, sprite0_hit
  );

  modport slave (
    input  pixel_en, pixel_x, bg_pixel, bg_palette, spr_pixel, spr_palette,
           spr_behind, spr_is_zero, ppumask_in, sprite0_clear, pal_data,
    output pal_addr, pal_rd_en, color_out, emphasis_out, color_valid, sprite0_hit
  );

endinterface

// File: rtl/ppu_priority_mux.sv
// Combinational left-column clipping, bg/sprite priority resolution and sprite-0 hit candidate.
module ppu_priority_mux
  import ppu_pkg::*;
#(
  parameter int LEFT_CLIP_W = 8,
  parameter int HIT_X_EXCL  = 255
) (
  input  logic [7:0] i_pixel_x,
  input  ppu_pix_t   i_bg,
  input  ppu_pix_t   i_spr,
  input  logic       i_spr_behind,
  input  logic       i_spr_is_zero,
  input  logic       i_show_bg,
  input  logic       i_show_spr,
  input  logic       i_bg_left,
  input  logic       i_spr_left,
  output logic [4:0] o_pal_addr,
  output logic       o_hit_cand
);

  logic w_past_clip;
  logic w_bg_vis;
  logic w_spr_vis;

  always_comb begin
    w_past_clip = (int'(i_pixel_x) >= LEFT_CLIP_W);
    w_bg_vis    = (i_bg.pixel != 2'b00) && i_show_bg && (w_past_clip || i_bg_left);
    w_spr_vis   = (i_spr.pixel != 2'b00) && i_show_spr && (w_past_clip || i_spr_left);

    // Sprite wins unless it is flagged behind and the background is opaque.
    o_pal_addr = BACKDROP_ADDR;
    if (w_spr_vis && !(w_bg_vis && i_spr_behind)) begin
      o_pal_addr = {1'b1, i_spr.palette, i_spr.pixel};
    end else if (w_bg_vis) begin
      o_pal_addr = {1'b0, i_bg.palette, i_bg.pixel};
    end

    o_hit_cand = w_bg_vis && w_spr_vis && i_spr_is_zero && (int'(i_pixel_x) != HIT_X_EXCL);
  end

endmodule

// File: rtl/ppu_pixel_mux.sv
// Final PPU pixel stage: palette address lookup, grayscale/emphasis tagging and sticky sprite-0 hit.
module ppu_pixel_mux
  import ppu_pkg::*;
#(
  parameter int LEFT_CLIP_W = 8,
  parameter int HIT_X_EXCL  = 255
) (
  input logic           clk,
  input logic           reset,
  ppu_pixel_mux_if.slave bus
);

  ppu_pix_t   w_bg;
  ppu_pix_t   w_spr;
  logic [4:0] w_pal_addr;
  logic       w_hit_cand;

  logic [4:0] r_pal_addr_p1;
  logic       r_vld_p1;
  logic       r_gray_p1;
  logic [2:0] r_emph_p1;
  logic [5:0] r_color_p2;
  logic [2:0] r_emph_p2;
  logic       r_vld_p2;
  logic       r_sprite0_hit;

  function automatic logic [5:0] f_grayscale(input logic i_gray, input logic [5:0] i_color);
    return i_gray ? (i_color & GRAY_MASK) : i_color;
  endfunction

  assign w_bg  = {bus.bg_pixel, bus.bg_palette};
  assign w_spr = {bus.spr_pixel, bus.spr_palette};

  ppu_priority_mux #(
    .LEFT_CLIP_W (LEFT_CLIP_W),
    .HIT_X_EXCL  (HIT_X_EXCL)
  ) u_priority (
    .i_pixel_x     (bus.pixel_x),
    .i_bg          (w_bg),
    .i_spr         (w_spr),
    .i_spr_behind  (bus.spr_behind),
    .i_spr_is_zero (bus.spr_is_zero),
    .i_show_bg     (bus.ppumask_in[SHOW_BG]),
    .i_show_spr    (bus.ppumask_in[SHOW_SPR]),
    .i_bg_left     (bus.ppumask_in[BG_LEFT]),
    .i_spr_left    (bus.ppumask_in[SPR_LEFT]),
    .o_pal_addr    (w_pal_addr),
    .o_hit_cand    (w_hit_cand)
  );

  // Stage 1: palette address and the mask bits this pixel will be finished with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_pal_addr_p1 <= '0;
      r_gray_p1     <= 1'b0;
      r_emph_p1     <= '0;
    end else begin
      r_vld_p1 <= bus.pixel_en;
      if (bus.pixel_en) begin
        r_pal_addr_p1 <= w_pal_addr;
        r_gray_p1     <= bus.ppumask_in[GRAY];
        r_emph_p1     <= bus.ppumask_in[EMPH_LSB +: 3];
      end
    end
  end

  // Stage 2: palette data returned; colour and emphasis hold between valid pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2   <= 1'b0;
      r_color_p2 <= '0;
      r_emph_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_color_p2 <= f_grayscale(r_gray_p1, bus.pal_data);
        r_emph_p2  <= r_emph_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sprite0_hit <= 1'b0;
    end else if (bus.sprite0_clear) begin
      r_sprite0_hit <= 1'b0;
    end else if (bus.pixel_en && w_hit_cand) begin
      r_sprite0_hit <= 1'b1;
    end
  end

  assign bus.pal_addr     = r_pal_addr_p1;
  assign bus.pal_rd_en    = r_vld_p1;
  assign bus.color_out    = r_color_p2;
  assign bus.emphasis_out = r_emph_p2;
  assign bus.color_valid  = r_vld_p2;
  assign bus.sprite0_hit  = r_sprite0_hit;

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Self-checking bench for ppu_pixel_mux: directed literal cases plus randomized traffic vs a reference model.
module tb_ppu_pixel_mux;

  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppu_pixel_mux_if bus ();

  ppu_pixel_mux #(
    .LEFT_CLIP_W (8),
    .HIT_X_EXCL  (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] pal_ram [32];
  assign bus.pal_data = pal_ram[bus.pal_addr];

  int n_chk = 0;
  int n_pass = 0;

  // Per-edge record of what was presented: index = count of clock edges seen.
  int         cyc = 0;
  int         rst_cyc = 0;
  bit         en_at   [NCYC];
  logic [4:0] addr_at [NCYC];
  bit         gray_at [NCYC];
  logic [2:0] emph_at [NCYC];
  bit         cand_at [NCYC];
  bit         clr_at  [NCYC];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit visible(input logic [1:0] px, input bit show, input bit left_ok,
                                 input logic [7:0] x);
    return (px != 2'd0) && show && ((x >= 8'd8) || left_ok);
  endfunction

  function automatic logic [4:0] ref_addr(input logic [7:0] m, input logic [7:0] x,
      input logic [1:0] bp, input logic [1:0] bpal, input logic [1:0] sp,
      input logic [1:0] spal, input bit behind);
    bit bv = visible(bp, m[3], m[1], x);
    bit sv = visible(sp, m[4], m[2], x);
    if (sv && bv) return behind ? {1'b0, bpal, bp} : {1'b1, spal, sp};
    if (sv) return {1'b1, spal, sp};
    if (bv) return {1'b0, bpal, bp};
    return 5'h00;
  endfunction

  function automatic bit ref_cand(input logic [7:0] m, input logic [7:0] x,
      input logic [1:0] bp, input logic [1:0] sp, input bit zero);
    return visible(bp, m[3], m[1], x) && visible(sp, m[4], m[2], x) && zero && (x != 8'd255);
  endfunction

  always @(posedge clk) begin
    if (cyc + 1 < NCYC) begin
      en_at[cyc+1]   <= !reset && bus.pixel_en;
      addr_at[cyc+1] <= ref_addr(bus.ppumask_in, bus.pixel_x, bus.bg_pixel, bus.bg_palette,
                                 bus.spr_pixel, bus.spr_palette, bus.spr_behind);
      gray_at[cyc+1] <= bus.ppumask_in[0];
      emph_at[cyc+1] <= bus.ppumask_in[7:5];
      cand_at[cyc+1] <= !reset && bus.pixel_en &&
                        ref_cand(bus.ppumask_in, bus.pixel_x, bus.bg_pixel, bus.spr_pixel, bus.spr_is_zero);
      clr_at[cyc+1]  <= !reset && bus.sprite0_clear;
    end
    cyc <= cyc + 1;
  end

  always @(posedge reset) rst_cyc <= cyc;

  // Every cycle: address one edge after a pixel, colour two edges after, sticky hit since last clear/reset.
  initial begin
    logic [5:0] m_color;
    logic [2:0] m_emph;
    m_color = '0;
    m_emph  = '0;
    forever begin
      int c;
      bit v1, v2, hit_e;
      @(negedge clk);
      c  = cyc;
      v1 = (c > rst_cyc) && en_at[c];
      v2 = (c >= 1) && (c - 1 > rst_cyc) && en_at[c-1];
      if (reset) begin
        m_color = '0;
        m_emph  = '0;
      end
      if (v2) begin
        m_color = gray_at[c-1] ? (pal_ram[addr_at[c-1]] & 6'h30) : pal_ram[addr_at[c-1]];
        m_emph  = emph_at[c-1];
      end
      hit_e = 1'b0;
      for (int k = c; k > rst_cyc && k > 0; k--) begin
        if (clr_at[k]) break;
        if (cand_at[k]) begin
          hit_e = 1'b1;
          break;
        end
      end
      chk("model_pal_rd_en", bus.pal_rd_en, v1);
      if (v1) chk("model_pal_addr", bus.pal_addr, addr_at[c]);
      chk("model_color_valid", bus.color_valid, v2);
      chk("model_color_out", bus.color_out, m_color);
      if (v2) chk("model_emphasis", bus.emphasis_out, m_emph);
      chk("model_sprite0_hit", bus.sprite0_hit, hit_e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pixel_en      = 1'b0;
    bus.sprite0_clear = 1'b0;
  endtask

  task automatic set_pix(input logic [7:0] x, input logic [1:0] bp, input logic [1:0] bpal,
      input logic [1:0] sp, input logic [1:0] spal, input bit behind, input bit zero,
      input logic [7:0] mask);
    bus.pixel_en    = 1'b1;
    bus.pixel_x     = x;
    bus.bg_pixel    = bp;
    bus.bg_palette  = bpal;
    bus.spr_pixel   = sp;
    bus.spr_palette = spal;
    bus.spr_behind  = behind;
    bus.spr_is_zero = zero;
    bus.ppumask_in  = mask;
  endtask

  initial begin
    logic [7:0] rmask;
    idle();
    set_pix(8'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00);
    bus.pixel_en = 1'b0;
    for (int i = 0; i < 32; i++) pal_ram[i] = 6'($urandom);
    pal_ram[5'h1B] = 6'h15;
    pal_ram[5'h06] = 6'h0C;
    pal_ram[5'h00] = 6'h2A;

    tick(); tick(); tick();
    chk("reset_pal_rd_en", bus.pal_rd_en, 0);
    chk("reset_pal_addr", bus.pal_addr, 0);
    chk("reset_color_valid", bus.color_valid, 0);
    chk("reset_color_out", bus.color_out, 0);
    chk("reset_sprite0_hit", bus.sprite0_hit, 0);
    reset = 1'b0;
    tick();

    // Sprite in front of opaque background.
    set_pix(8'd20, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0, 8'h1E);
    tick(); idle();
    chk("front_pal_rd_en", bus.pal_rd_en, 1);
    chk("front_pal_addr", bus.pal_addr, 5'h1B);
    tick();
    chk("front_color_valid", bus.color_valid, 1);
    chk("front_color_out", bus.color_out, 6'h15);

    set_pix(8'd20, 2'd2, 2'd1, 2'd3, 2'd2, 1'b1, 1'b1, 8'h1E);
    tick(); idle();
    chk("behind_pal_addr", bus.pal_addr, 5'h06);
    chk("behind_hit", bus.sprite0_hit, 1);
    tick();
    chk("behind_color_out", bus.color_out, 6'h0C);

    bus.sprite0_clear = 1'b1;
    tick(); idle();
    chk("clear_hit", bus.sprite0_hit, 0);
    set_pix(8'd20, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'h1E);
    bus.sprite0_clear = 1'b1;
    tick(); idle();
    chk("clear_wins_hit", bus.sprite0_hit, 0);
    tick();

    // Left-column clipping, then the first unclipped column.
    set_pix(8'd5, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'h18);
    tick(); idle();
    chk("clip_pal_addr", bus.pal_addr, 5'h00);
    chk("clip_hit", bus.sprite0_hit, 0);
    set_pix(8'd8, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'h18);
    tick(); idle();
    chk("x8_pal_addr", bus.pal_addr, 5'h1B);
    chk("x8_hit", bus.sprite0_hit, 1);
    tick();

    // Grayscale and emphasis are locked when the pixel enters.
    set_pix(8'd20, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'hE1);
    tick(); idle();
    bus.ppumask_in = 8'h1E;
    chk("gray_pal_addr", bus.pal_addr, 5'h00);
    tick();
    chk("gray_color_out", bus.color_out, 6'h20);
    chk("gray_emphasis", bus.emphasis_out, 3'b111);
    tick();
    chk("hold_color_valid", bus.color_valid, 0);
    chk("hold_color_out", bus.color_out, 6'h20);

    bus.sprite0_clear = 1'b1;
    tick(); idle();
    set_pix(8'd255, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'h1E);
    tick(); idle();
    chk("x255_hit", bus.sprite0_hit, 0);
    set_pix(8'd254, 2'd2, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 8'h1E);
    tick(); idle();
    chk("x254_hit", bus.sprite0_hit, 1);

    // Reset with two pixels in flight.
    set_pix(8'd30, 2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 8'h1E);
    tick();
    set_pix(8'd31, 2'd0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 8'h1E);
    tick(); idle();
    #2 reset = 1'b1;
    #1;
    chk("midrst_pal_rd_en", bus.pal_rd_en, 0);
    chk("midrst_pal_addr", bus.pal_addr, 0);
    chk("midrst_color_valid", bus.color_valid, 0);
    chk("midrst_color_out", bus.color_out, 0);
    chk("midrst_hit", bus.sprite0_hit, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("postrst_color_valid_a", bus.color_valid, 0);
    tick();
    chk("postrst_color_valid_b", bus.color_valid, 0);

    for (int i = 0; i < 2500; i++) begin
      rmask = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rmask[4:3] = 2'b11;
      set_pix(8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), rmask);
      case ($urandom_range(0, 3))
        0: bus.pixel_x = 8'($urandom_range(0, 15));
        1: bus.pixel_x = 8'($urandom_range(250, 255));
        default: ;
      endcase
      bus.pixel_en      = ($urandom_range(0, 3) != 0);
      bus.sprite0_clear = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
